matadd_sched: RTL

MATADD_SCHED -- requirements
Module: matadd_sched

---
 rtl/matadd_sched.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/matadd_sched.sv
// Round-robin scheduler sharing one pipelined 32-bit adder between two matrix-add requesters.
// Build option: MATADD_SCHED_SAT_EN selects a signed saturating sum instead of a wrapping one.
module matadd_sched #(
    parameter int unsigned ROWS    = 2,
    parameter int unsigned COLS    = 3,
    parameter int unsigned ADD_LAT = 2,
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    output logic [1:0]    grant,
    output logic          rd_valid,
    output logic [RW-1:0] rd_row,
    output logic [CW-1:0] rd_col,
    input  logic [31:0]   a_in,
    input  logic [31:0]   b_in,
    output logic          wr_valid,
    output logic [RW-1:0] wr_row,
    output logic [CW-1:0] wr_col,
    output logic [31:0]   wr_data,
    output logic [1:0]    done,
    output logic          busy
);

    localparam int unsigned DW = $clog2(ADD_LAT + 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [DW-1:0] CNT_LAST = DW'(ADD_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic          v;
        logic [RW-1:0] r;
        logic [CW-1:0] c;
        logic [31:0]   d;
    } wr_t;

    state_t        state, state_d;
    logic [RW-1:0] row_d;
    logic [CW-1:0] col_d;
    logic [DW-1:0] cnt, cnt_d;
    logic [1:0]    grant_d, done_d;
    logic          rr_ptr, rr_d, win;
    logic          rd_valid_d, busy_d;
    logic [31:0]   sum_c;
    wr_t           stage_in;
    wr_t           pipe [ADD_LAT];

    // Adder datapath
`ifdef MATADD_SCHED_SAT_EN
    logic [31:0] raw_c;
    logic        ovf_c;
    always_comb begin
        raw_c = a_in + b_in;
        ovf_c = (a_in[31] == b_in[31]) && (raw_c[31] != a_in[31]);
        sum_c = raw_c;
        if (ovf_c) sum_c = a_in[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
`else
    always_comb sum_c = a_in + b_in;
`endif

    // Next-state, arbitration and index sequencing
    always_comb begin
        state_d  = state;
        row_d    = rd_row;
        col_d    = rd_col;
        cnt_d    = cnt;
        grant_d  = grant;
        rr_d     = rr_ptr;
        done_d   = 2'b00;
        win      = 1'b0;
        case (state)
            IDLE: begin
                grant_d = 2'b00;
                row_d   = '0;
                col_d   = '0;
                if (req != 2'b00) begin
                    win     = (req == 2'b11) ? rr_ptr : req[1];
                    grant_d = win ? 2'b10 : 2'b01;
                    rr_d    = ~win;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (rd_row == ROW_LAST && rd_col == COL_LAST) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                end else if (rd_col == COL_LAST) begin
                    col_d = '0;
                    row_d = rd_row + RW'(1);
                end else begin
                    col_d = rd_col + CW'(1);
                end
            end
            DRAIN: begin
                if (cnt == CNT_LAST) begin
                    state_d = DONE;
                    done_d  = grant;
                end else begin
                    cnt_d = cnt + DW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
            default: state_d = IDLE;
        endcase
        rd_valid_d = (state_d == ISSUE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= 2'b00;
            rd_valid <= 1'b0;
            rd_row   <= '0;
            rd_col   <= '0;
            cnt      <= '0;
            rr_ptr   <= 1'b0;
            done     <= 2'b00;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            grant    <= grant_d;
            rd_valid <= rd_valid_d;
            rd_row   <= row_d;
            rd_col   <= col_d;
            cnt      <= cnt_d;
            rr_ptr   <= rr_d;
            done     <= done_d;
            busy     <= busy_d;
        end
    end

    // Result pipeline carries index alongside the sum so writes line up with issue order
    always_comb begin
        stage_in.v = rd_valid;
        stage_in.r = rd_row;
        stage_in.c = rd_col;
        stage_in.d = rd_valid ? sum_c : 32'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ADD_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= stage_in;
            for (int i = 1; i < ADD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign wr_valid = pipe[ADD_LAT-1].v;
    assign wr_row   = pipe[ADD_LAT-1].r;
    assign wr_col   = pipe[ADD_LAT-1].c;
    assign wr_data  = pipe[ADD_LAT-1].d;

endmodule
